// File: rtl/bus_pkg.sv
// Shared types for the CPU-to-peripheral bus fabric: FSM state encoding and
// the value returned on a failed access.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } bus_state_e;

  // Sliced down to DATA_W by users; a failed access always reads all ones.
  localparam logic [63:0] BUS_ERR_RDATA = '1;

endpackage

// File: rtl/bus_fabric_if.sv
// CPU-side bus of the fabric. Handshake: the CPU holds cpu_r/cpu_w (and addr/wdata)
// steady until cpu_ready pulses for one cycle; bus_error qualifies that pulse.
interface bus_fabric_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_r;
  logic              cpu_w;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              bus_error;

  modport master (
    output cpu_addr, cpu_wdata, cpu_r, cpu_w,
    input  cpu_rdata, cpu_ready, bus_error
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_r, cpu_w,
    output cpu_rdata, cpu_ready, bus_error
  );
endinterface

// File: rtl/bus_decode.sv
// Combinational base/mask address decoder; the lowest-index matching slot wins
// and a zero mask takes the slot out of the map entirely.
module bus_decode #(
  parameter int SLOTS  = 8,
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 3
) (
  input  logic [ADDR_W-1:0]       addr,
  input  logic [SLOTS*ADDR_W-1:0] base,
  input  logic [SLOTS*ADDR_W-1:0] mask,
  output logic                    hit,
  output logic [IDX_W-1:0]        idx
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if ((mask[i*ADDR_W +: ADDR_W] != '0) &&
          ((addr & mask[i*ADDR_W +: ADDR_W]) ==
           (base[i*ADDR_W +: ADDR_W] & mask[i*ADDR_W +: ADDR_W]))) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// Memory-mapped interconnect between the CPU and up to SLOTS peripherals, with
// wait states, slot ready, bus timeout and a stretched peripheral reset.
module bus_fabric
  import bus_pkg::*;
#(
  parameter int SLOTS      = 8,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RESET_HOLD = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic                    sys_reset,
  bus_fabric_if.slave             cpu,
  input  logic [SLOTS*ADDR_W-1:0] slot_base,
  input  logic [SLOTS*ADDR_W-1:0] slot_mask,
  input  logic [SLOTS*4-1:0]      slot_wait,
  output logic [SLOTS-1:0]        slot_cs,
  output logic                    slot_r,
  output logic                    slot_w,
  output logic [ADDR_W-1:0]       slot_addr,
  output logic [DATA_W-1:0]       slot_wdata,
  input  logic [SLOTS*DATA_W-1:0] slot_rdata,
  input  logic [SLOTS-1:0]        slot_ready,
  output bus_state_e              dbg_state
);

  localparam int IDX_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int HCNT_W = $clog2(RESET_HOLD + 1);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  bus_state_e          state_q, state_d;
  logic [HCNT_W-1:0]   hcnt_q;
  logic [TCNT_W-1:0]   tcnt_q;
  logic [3:0]          wcnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic                op_r_q, op_w_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ready_q, err_q, armed_q, sys_reset_q;
  logic [SLOTS-1:0]    cs_q;

  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic                strobe, issue, access_done;
  logic [IDX_W-1:0]    cs_idx;
  logic [DATA_W-1:0]   sel_rdata;

  bus_decode #(
    .SLOTS  (SLOTS),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_decode (
    .addr (cpu.cpu_addr),
    .base (slot_base),
    .mask (slot_mask),
    .hit  (hit),
    .idx  (hit_idx)
  );

  assign strobe      = cpu.cpu_r | cpu.cpu_w;
  assign issue       = (state_q == ST_IDLE) && armed_q && strobe;
  assign access_done = (wcnt_q == 4'd0) && slot_ready[idx_q];
  assign sel_rdata   = slot_rdata[idx_q*DATA_W +: DATA_W];
  assign cs_idx      = issue ? hit_idx : idx_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_HOLD;
    else          state_q <= state_d;
  end

  // Completion wins over timeout on the cycle the two coincide.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD:   if (hcnt_q == HCNT_W'(RESET_HOLD)) state_d = ST_IDLE;
      ST_IDLE:   if (issue) state_d = (!hit || (cpu.cpu_r && cpu.cpu_w)) ? ST_ERR : ST_ACCESS;
      ST_ACCESS: begin
        if (access_done)                        state_d = ST_DONE;
        else if (tcnt_q == TCNT_W'(TIMEOUT))    state_d = ST_ERR;
      end
      ST_DONE, ST_ERR: state_d = ST_IDLE;
      default:   state_d = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      cs_q        <= '0;
      op_r_q      <= 1'b0;
      op_w_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      idx_q       <= '0;
      wcnt_q      <= '0;
      tcnt_q      <= '0;
      hcnt_q      <= '0;
      armed_q     <= 1'b0;
    end else begin
      sys_reset_q <= (state_d == ST_HOLD);
      ready_q     <= (state_d == ST_DONE) || (state_d == ST_ERR);
      err_q       <= (state_d == ST_ERR);
      cs_q        <= (state_d == ST_ACCESS) ? (SLOTS'(1) << cs_idx) : '0;

      if (state_q == ST_HOLD) hcnt_q <= hcnt_q + HCNT_W'(1);

      // A strobe must be seen low before the next request is taken.
      if (issue) begin
        armed_q <= 1'b0;
        addr_q  <= cpu.cpu_addr;
        wdata_q <= cpu.cpu_wdata;
        op_r_q  <= cpu.cpu_r;
        op_w_q  <= cpu.cpu_w;
        idx_q   <= hit_idx;
        wcnt_q  <= slot_wait[hit_idx*4 +: 4];
        tcnt_q  <= TCNT_W'(1);
      end else if (!strobe) begin
        armed_q <= 1'b1;
      end

      if (state_q == ST_ACCESS) begin
        if (wcnt_q != 4'd0)        wcnt_q <= wcnt_q - 4'd1;
        if (state_d == ST_ACCESS)  tcnt_q <= tcnt_q + TCNT_W'(1);
      end

      if (state_d == ST_ERR)                   rdata_q <= BUS_ERR_RDATA[DATA_W-1:0];
      else if (state_d == ST_DONE && op_r_q)   rdata_q <= sel_rdata;
    end
  end

  assign sys_reset     = sys_reset_q;
  assign cpu.cpu_rdata = rdata_q;
  assign cpu.cpu_ready = ready_q;
  assign cpu.bus_error = err_q;
  assign slot_cs       = cs_q;
  assign slot_r        = op_r_q & (state_q == ST_ACCESS);
  assign slot_w        = op_w_q & (state_q == ST_ACCESS);
  assign slot_addr     = addr_q;
  assign slot_wdata    = wdata_q;
  assign dbg_state     = state_q;

endmodule
